// File: rtl/timing_pulse_generator.sv
// timing_pulse_generator
//   Generates a one-hot sequence of NUM_PULSES timing pulses per memory
//   cycle and counts the completed cycles.
//
//   Parameters
//     NUM_PULSES  pulses per memory cycle (2..32)
//     CYC_W       width of the completed-cycle counter (1..32)
//
//   Ports
//     clk          rising-edge clock
//     rst_n        synchronous active-low reset
//     en           run enable, used in CONTINUOUS mode only
//     mode         0=CONTINUOUS 1=SINGLE 2=STEP 3=STOP
//     step         start strobe (SINGLE) / advance strobe (STEP)
//     tp           registered one-hot timing pulses, bit 0 first
//     tp_idx       index of the asserted tp bit, 0 when idle
//     mct_end      high while the last pulse is asserted
//     cycle_count  completed memory cycles, wraps modulo 2^CYC_W
//     busy         high while any pulse is asserted
module timing_pulse_generator #(
  parameter int NUM_PULSES = 12,
  parameter int CYC_W      = 16,
  localparam int IDX_W     = ($clog2(NUM_PULSES) < 1) ? 1 : $clog2(NUM_PULSES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  step,
  output logic [NUM_PULSES-1:0] tp,
  output logic [IDX_W-1:0]      tp_idx,
  output logic                  mct_end,
  output logic [CYC_W-1:0]      cycle_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    MODE_CONT   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_STEP   = 2'd2,
    MODE_STOP   = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [NUM_PULSES-1:0] FIRST_PULSE = NUM_PULSES'(1);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_PULSES - 1);
  localparam logic [IDX_W-1:0]      PRE_LAST    = IDX_W'(NUM_PULSES - 2);

  state_e state;
  mode_e  cur_mode;
  logic   advance;
  logic   at_last;

  always_comb begin
    cur_mode = mode_e'(mode);
    at_last  = (state == ACTIVE) && (tp_idx == LAST_IDX);
    advance  = 1'b0;
    unique case (cur_mode)
      MODE_CONT:   advance = en;
      // Once started, a single cycle runs to completion on its own;
      // step only matters while idle.
      MODE_SINGLE: advance = (state == ACTIVE) ? 1'b1 : step;
      MODE_STEP:   advance = step;
      MODE_STOP:   advance = 1'b0;
      default:     advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tp          <= '0;
      tp_idx      <= '0;
      mct_end     <= 1'b0;
      busy        <= 1'b0;
      cycle_count <= '0;
    end else if (cur_mode == MODE_STOP) begin
      // Abort without crediting a cycle, even from the last pulse.
      state   <= IDLE;
      tp      <= '0;
      tp_idx  <= '0;
      mct_end <= 1'b0;
      busy    <= 1'b0;
    end else if (advance) begin
      if (at_last) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
      if (at_last && (cur_mode == MODE_SINGLE)) begin
        state   <= IDLE;
        tp      <= '0;
        tp_idx  <= '0;
        mct_end <= 1'b0;
        busy    <= 1'b0;
      end else if ((state == IDLE) || at_last) begin
        state   <= ACTIVE;
        tp      <= FIRST_PULSE;
        tp_idx  <= '0;
        mct_end <= 1'b0;
        busy    <= 1'b1;
      end else begin
        state   <= ACTIVE;
        tp      <= tp << 1;
        tp_idx  <= tp_idx + IDX_W'(1);
        mct_end <= (tp_idx == PRE_LAST);
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timing_pulse_generator.sv
// tb_timing_pulse_generator
//   Directed bench for timing_pulse_generator with NUM_PULSES=12. A main
//   instance (CYC_W=16) and a narrow-counter instance (CYC_W=4) share the
//   same inputs; the narrow one exercises counter wrap.
module tb_timing_pulse_generator;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic        step;

  logic [11:0] tp;
  logic [3:0]  tp_idx;
  logic        mct_end;
  logic [15:0] cycle_count;
  logic        busy;

  logic [11:0] tp_s;
  logic [3:0]  tp_idx_s;
  logic        mct_end_s;
  logic [3:0]  cycle_count_s;
  logic        busy_s;

  int tests;
  int fails;

  timing_pulse_generator #(.NUM_PULSES(12), .CYC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
    .tp(tp), .tp_idx(tp_idx), .mct_end(mct_end),
    .cycle_count(cycle_count), .busy(busy)
  );

  timing_pulse_generator #(.NUM_PULSES(12), .CYC_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
    .tp(tp_s), .tp_idx(tp_idx_s), .mct_end(mct_end_s),
    .cycle_count(cycle_count_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Advance one clock, then check structural consistency of the outputs.
  task automatic tick();
    logic [11:0] onehot;
    logic        ok;
    @(posedge clk);
    #1;
    onehot = (tp == 12'h000) ? 12'h000 : (12'h001 << tp_idx);
    ok = (tp === onehot) && ((tp != 12'h000) || (tp_idx == 4'd0)) &&
         (mct_end === tp[11]) && (busy === (|tp)) && (tp_s === tp) &&
         (tp_idx_s === tp_idx) && (mct_end_s === mct_end) && (busy_s === busy);
    chk("invariant", {31'd0, ok}, 32'd1);
  endtask

  task automatic exp_state(input string tag, input logic [11:0] want_tp, input logic [15:0] want_cc);
    logic [3:0] want_idx;
    want_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (want_tp[i]) want_idx = 4'(i);
    end
    chk({tag, ".tp"},      {20'd0, tp},          {20'd0, want_tp});
    chk({tag, ".tp_idx"},  {28'd0, tp_idx},      {28'd0, want_idx});
    chk({tag, ".mct_end"}, {31'd0, mct_end},     {31'd0, want_tp[11]});
    chk({tag, ".busy"},    {31'd0, busy},        {31'd0, |want_tp});
    chk({tag, ".cc"},      {16'd0, cycle_count}, {16'd0, want_cc});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    step  = 1'b0;
    #1;

    // Reset state
    tick(); tick();
    exp_state("reset", 12'h000, 16'd0);
    chk("reset.cc_small", {28'd0, cycle_count_s}, 32'd0);

    // CONTINUOUS from reset release
    rst_n = 1'b1; mode = 2'd0; en = 1'b1;
    tick();           exp_state("cont.e1",   12'h001, 16'd0);
    tick();           exp_state("cont.e2",   12'h002, 16'd0);
    repeat (10) tick(); exp_state("cont.e12",  12'h800, 16'd0);
    tick();           exp_state("cont.e13",  12'h001, 16'd1);
    repeat (108) tick(); exp_state("cont.e121", 12'h001, 16'd10);
    repeat (60) tick();  exp_state("cont.e181", 12'h001, 16'd15);
    chk("wrap.cc_small_15", {28'd0, cycle_count_s}, 32'd15);
    repeat (12) tick();  exp_state("cont.e193", 12'h001, 16'd16);
    chk("wrap.cc_small_0", {28'd0, cycle_count_s}, 32'd0);
    repeat (12) tick();  exp_state("cont.e205", 12'h001, 16'd17);
    chk("wrap.cc_small_1", {28'd0, cycle_count_s}, 32'd1);

    // CONTINUOUS hold with en low
    repeat (4) tick(); exp_state("hold.pre", 12'h010, 16'd17);
    en = 1'b0;
    repeat (3) begin
      tick(); exp_state("hold.en0", 12'h010, 16'd17);
    end
    en = 1'b1;
    tick(); exp_state("hold.resume", 12'h020, 16'd17);

    // SINGLE
    rst_n = 1'b0;
    tick(); exp_state("single.rst", 12'h000, 16'd0);
    rst_n = 1'b1; mode = 2'd1; en = 1'b0; step = 1'b1;
    tick(); exp_state("single.start", 12'h001, 16'd0);
    step = 1'b0;
    repeat (6) tick(); exp_state("single.e7", 12'h040, 16'd0);
    step = 1'b1;
    tick(); exp_state("single.restep", 12'h080, 16'd0);
    step = 1'b0;
    repeat (4) tick(); exp_state("single.last", 12'h800, 16'd0);
    tick(); exp_state("single.done", 12'h000, 16'd1);
    tick(); exp_state("single.idle", 12'h000, 16'd1);

    // STEP
    rst_n = 1'b0;
    tick(); exp_state("step.rst", 12'h000, 16'd0);
    rst_n = 1'b1; mode = 2'd2; step = 1'b1;
    tick(); exp_state("step.s1", 12'h001, 16'd0);
    step = 1'b0;
    tick(); exp_state("step.hold1", 12'h001, 16'd0);
    step = 1'b1;
    tick(); exp_state("step.s2", 12'h002, 16'd0);
    step = 1'b0;
    repeat (2) tick(); exp_state("step.hold2", 12'h002, 16'd0);
    step = 1'b1;
    tick(); exp_state("step.s3", 12'h004, 16'd0);
    repeat (9) tick(); exp_state("step.s12", 12'h800, 16'd0);
    tick(); exp_state("step.s13", 12'h001, 16'd1);
    step = 1'b0;

    // Reset mid-cycle, then STOP from last pulse
    rst_n = 1'b0; mode = 2'd0; en = 1'b1;
    tick(); exp_state("mid.rst0", 12'h000, 16'd0);
    rst_n = 1'b1;
    repeat (61) tick(); exp_state("mid.cc5", 12'h001, 16'd5);
    repeat (9) tick();  exp_state("mid.tp200", 12'h200, 16'd5);
    rst_n = 1'b0;
    tick(); exp_state("mid.rst", 12'h000, 16'd0);
    rst_n = 1'b1;
    tick(); exp_state("mid.first", 12'h001, 16'd0);
    repeat (23) tick(); exp_state("stop.pre", 12'h800, 16'd1);
    mode = 2'd3;
    tick(); exp_state("stop.e1", 12'h000, 16'd1);
    tick(); exp_state("stop.e2", 12'h000, 16'd1);

    // Mode changes mid-cycle continue from current position
    mode = 2'd0; en = 1'b1;
    tick(); exp_state("chg.cont", 12'h001, 16'd1);
    mode = 2'd2; step = 1'b0;
    tick(); exp_state("chg.step_hold", 12'h001, 16'd1);
    step = 1'b1;
    tick(); exp_state("chg.step_adv", 12'h002, 16'd1);
    mode = 2'd1; step = 1'b0; en = 1'b0;
    tick(); exp_state("chg.single", 12'h004, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
